// File: rtl/label_ram_writer_pkg.sv
// Shared command codes and parser state encoding for the label RAM writer.
// Host-side tooling and the bench import the same definitions.
package label_ram_writer_pkg;

   localparam logic [7:0] CMD_SETADDR = 8'h01;
   localparam logic [7:0] CMD_WRITE   = 8'h02;
   localparam logic [7:0] CMD_FILL    = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_DATA,
      ST_FVAL,
      ST_FILL
   } state_t;

   // A length byte of zero encodes a full 256-byte burst.
   function automatic logic [8:0] burstLen(input logic [7:0] lenByte);
      return (lenByte == 8'd0) ? 9'd256 : {1'b0, lenByte};
   endfunction

endpackage

// File: rtl/label_ram_writer_idle_timer.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// pulses o_expire on the cycle the count would reach TIMEOUT.
module idle_timer #(
   parameter int TIMEOUT = 12000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // A clear on the expiry cycle wins, so a late byte is never lost.
   assign o_expire = i_enable && !i_clear && (count_q == LAST);

   always_comb begin
      count_d = count_q + CW'(1);
      if (i_clear || !i_enable || o_expire) begin
         count_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/label_ram_writer.sv
// Byte-stream command parser driving the label RAM write port:
// set-address, auto-incrementing burst write and whole-RAM fill.
module label_ram_writer
   import label_ram_writer_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 12000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr,
   input  logic [7:0]        i_data,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [7:0]        o_ram_din,
   output logic              o_busy,
   output logic              o_ack,
   output logic              o_err
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [8:0]        remain_q, remain_d;
   logic [7:0]        fillVal_q, fillVal_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              busy_q, busy_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              errPend_q, errPend_d;
   logic              ackNow;
   logic              errNow;
   logic              timerEn;
   logic              expire;

   assign timerEn = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_FVAL);

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (i_wr),
      .i_enable (timerEn),
      .o_expire (expire)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      remain_d  = remain_q;
      fillVal_d = fillVal_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      din_d     = din_q;
      busy_d    = 1'b0;
      ackNow    = 1'b0;
      errNow    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_wr) begin
               if (i_data == CMD_SETADDR) begin
                  state_d = ST_ADDR;
               end else if (i_data == CMD_WRITE) begin
                  state_d = ST_LEN;
               end else if (i_data == CMD_FILL) begin
                  state_d = ST_FVAL;
               end else begin
                  errNow = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (i_wr) begin
               ptr_d   = i_data[ADDR_W-1:0];
               ackNow  = 1'b1;
               state_d = ST_IDLE;
            end else if (expire) begin
               errNow  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_LEN: begin
            if (i_wr) begin
               remain_d = burstLen(i_data);
               state_d  = ST_DATA;
            end else if (expire) begin
               errNow  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (i_wr) begin
               we_d     = 1'b1;
               addr_d   = ptr_q;
               din_d    = i_data;
               ptr_d    = ptr_q + ADDR_W'(1);
               remain_d = remain_q - 9'd1;
               if (remain_q == 9'd1) begin
                  ackNow  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (expire) begin
               errNow  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FVAL: begin
            // The value byte itself triggers the write to address 0.
            if (i_wr) begin
               fillVal_d = i_data;
               we_d      = 1'b1;
               addr_d    = '0;
               din_d     = i_data;
               busy_d    = 1'b1;
               ptr_d     = ADDR_W'(1);
               state_d   = ST_FILL;
            end else if (expire) begin
               errNow  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            we_d   = 1'b1;
            addr_d = ptr_q;
            din_d  = fillVal_q;
            busy_d = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
            errNow = i_wr;
            if (ptr_q == {ADDR_W{1'b1}}) begin
               ackNow  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A byte dropped on the final fill cycle would collide with the ack;
      // its error pulse is deferred by one cycle instead of being merged.
      ack_d = ackNow;
      if (ackNow) begin
         err_d     = 1'b0;
         errPend_d = errPend_q | errNow;
      end else begin
         err_d     = errNow | errPend_q;
         errPend_d = errNow & errPend_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         remain_q  <= '0;
         fillVal_q <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         errPend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         remain_q  <= remain_d;
         fillVal_q <= fillVal_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         errPend_q <= errPend_d;
      end
   end

   assign o_ram_we   = we_q;
   assign o_ram_addr = addr_q;
   assign o_ram_din  = din_q;
   assign o_busy     = busy_q;
   assign o_ack      = ack_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_label_ram_writer.sv
// Self-checking bench for label_ram_writer: a command-level model predicts
// every output cycle, plus directed scenarios pinned by literal expectations.
module tb_label_ram_writer;
   import label_ram_writer_pkg::*;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 40;
   localparam int RAMSIZE = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              wr;
   logic [7:0]        dat;
   logic              ramWe;
   logic [ADDR_W-1:0] ramAddr;
   logic [7:0]        ramDin;
   logic              busy;
   logic              ack;
   logic              err;

   int tests;
   int fails;

   label_ram_writer #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wr       (wr),
      .i_data     (dat),
      .o_ram_we   (ramWe),
      .o_ram_addr (ramAddr),
      .o_ram_din  (ramDin),
      .o_busy     (busy),
      .o_ack      (ack),
      .o_err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Command-level model: what the next cycle's outputs must be.
   int  mCmd;
   bit  mLenKnown;
   int  mLeft;
   int  mPtr;
   int  mIdle;
   int  mFillLeft;
   int  mFillIdx;
   int  mFillV;
   int  mErrOwed;
   bit  mValid;
   bit  eWe;
   int  eAddr;
   int  eDin;
   bit  eBusy;
   bit  eAck;
   bit  eErr;

   always @(posedge clk) begin
      bit errNow;
      errNow = 1'b0;
      eWe    = 1'b0;
      eBusy  = 1'b0;
      eAck   = 1'b0;
      eErr   = 1'b0;
      if (!rst_n) begin
         mCmd = 0; mLenKnown = 1'b0; mLeft = 0; mPtr = 0; mIdle = 0;
         mFillLeft = 0; mFillIdx = 0; mFillV = 0; mErrOwed = 0;
         mValid = 1'b1;
      end else if (mFillLeft > 0) begin
         eWe = 1'b1; eBusy = 1'b1; eAddr = mFillIdx; eDin = mFillV;
         mFillIdx = mFillIdx + 1;
         mFillLeft = mFillLeft - 1;
         if (mFillLeft == 0) begin
            eAck = 1'b1;
            mPtr = 0;
         end
         if (wr) errNow = 1'b1;
      end else if (mCmd == 0) begin
         if (wr) begin
            mIdle = 0;
            if (dat == CMD_SETADDR || dat == CMD_WRITE || dat == CMD_FILL) begin
               mCmd = int'(dat);
               mLenKnown = 1'b0;
            end else begin
               errNow = 1'b1;
            end
         end
      end else if (wr) begin
         mIdle = 0;
         if (mCmd == 1) begin
            mPtr = int'(dat) % RAMSIZE;
            eAck = 1'b1;
            mCmd = 0;
         end else if (mCmd == 2 && !mLenKnown) begin
            mLeft = (dat == 8'd0) ? 256 : int'(dat);
            mLenKnown = 1'b1;
         end else if (mCmd == 2) begin
            eWe = 1'b1; eAddr = mPtr; eDin = int'(dat);
            mPtr = (mPtr + 1) % RAMSIZE;
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
               eAck = 1'b1;
               mCmd = 0;
            end
         end else begin
            mFillV = int'(dat);
            eWe = 1'b1; eBusy = 1'b1; eAddr = 0; eDin = mFillV;
            mFillIdx = 1;
            mFillLeft = RAMSIZE - 1;
            mCmd = 0;
         end
      end else begin
         mIdle = mIdle + 1;
         if (mIdle == TIMEOUT) begin
            errNow = 1'b1;
            mCmd = 0;
            mIdle = 0;
         end
      end
      if (rst_n) begin
         mErrOwed = mErrOwed + (errNow ? 1 : 0);
         if (!eAck && mErrOwed > 0) begin
            eErr = 1'b1;
            mErrOwed = mErrOwed - 1;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests = tests + 1;
      if (actual != expected) begin
         fails = fails + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle compare plus shadow RAM and event counters.
   logic [7:0] mem [RAMSIZE];
   int writeCount, ackCount, errCount, busyCount, ackWithWe;

   always @(negedge clk) begin
      if (rst_n && mValid) begin
         checkOutput("o_ram_we", int'(ramWe), int'(eWe));
         if (eWe) begin
            checkOutput("o_ram_addr", int'(ramAddr), eAddr);
            checkOutput("o_ram_din", int'(ramDin), eDin);
         end
         checkOutput("o_busy", int'(busy), int'(eBusy));
         checkOutput("o_ack", int'(ack), int'(eAck));
         checkOutput("o_err", int'(err), int'(eErr));
         if (ack && err) checkOutput("ack_err_exclusive", 1, 0);
         if (ramWe) begin
            mem[ramAddr] = ramDin;
            writeCount = writeCount + 1;
         end
         if (ack) ackCount = ackCount + 1;
         if (err) errCount = errCount + 1;
         if (busy) busyCount = busyCount + 1;
         if (ack && ramWe) ackWithWe = ackWithWe + 1;
      end
   end

   task automatic applyStimulus(input bit w, input logic [7:0] b);
      @(posedge clk);
      #1;
      wr  = w;
      dat = b;
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
   endtask

   int w0, a0, e0, b0, aw0;

   task automatic snap();
      w0 = writeCount; a0 = ackCount; e0 = errCount; b0 = busyCount; aw0 = ackWithWe;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int allFill;
      tests = 0; fails = 0; mValid = 1'b0;
      writeCount = 0; ackCount = 0; errCount = 0; busyCount = 0; ackWithWe = 0;
      for (int i = 0; i < RAMSIZE; i++) mem[i] = 8'h00;
      rst_n = 1'b0; wr = 1'b0; dat = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_we", int'(ramWe), 0);
      checkOutput("reset_addr", int'(ramAddr), 0);
      checkOutput("reset_din", int'(ramDin), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_ack", int'(ack), 0);
      checkOutput("reset_err", int'(err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Set address then a three-byte burst.
      snap();
      sendByte(8'h01); sendByte(8'h10); sendByte(8'h02); sendByte(8'h03);
      sendByte(8'h41); sendByte(8'h42); sendByte(8'h43);
      idle(3);
      checkOutput("t1_mem10", int'(mem[8'h10]), 8'h41);
      checkOutput("t1_mem11", int'(mem[8'h11]), 8'h42);
      checkOutput("t1_mem12", int'(mem[8'h12]), 8'h43);
      checkOutput("t1_writes", writeCount - w0, 3);
      checkOutput("t1_acks", ackCount - a0, 2);
      checkOutput("t1_ack_with_write", ackWithWe - aw0, 1);

      // Burst wrapping past the top of the address space.
      sendByte(8'h01); sendByte(8'hFE);
      sendByte(8'h02); sendByte(8'h03); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
      sendByte(8'h02); sendByte(8'h01); sendByte(8'h5A);
      idle(3);
      checkOutput("t2_memFE", int'(mem[8'hFE]), 8'hAA);
      checkOutput("t2_memFF", int'(mem[8'hFF]), 8'hBB);
      checkOutput("t2_mem00", int'(mem[8'h00]), 8'hCC);
      checkOutput("t2_mem01_ptr", int'(mem[8'h01]), 8'h5A);

      // Fill with a byte injected mid-fill.
      snap();
      sendByte(8'h03); sendByte(8'h20);
      idle(99);
      sendByte(8'h55);
      idle(200);
      allFill = 1;
      for (int i = 0; i < RAMSIZE; i++) if (mem[i] != 8'h20) allFill = 0;
      checkOutput("t3_all_filled", allFill, 1);
      checkOutput("t3_writes", writeCount - w0, 256);
      checkOutput("t3_busy_cycles", busyCount - b0, 256);
      checkOutput("t3_acks", ackCount - a0, 1);
      checkOutput("t3_errs", errCount - e0, 1);
      checkOutput("t3_ack_with_write", ackWithWe - aw0, 1);

      // Zero length means a 256-byte burst.
      snap();
      sendByte(8'h02); sendByte(8'h00);
      for (int i = 0; i < 256; i++) sendByte(8'(i ^ 8'h5A));
      idle(2);
      checkOutput("t4_writes", writeCount - w0, 256);
      checkOutput("t4_acks", ackCount - a0, 1);
      checkOutput("t4_mem00", int'(mem[8'h00]), 8'h5A);
      sendByte(8'h01); sendByte(8'h07);
      idle(2);
      checkOutput("t4_next_cmd_ack", ackCount - a0, 2);

      // Timeout mid-burst, then recovery.
      snap();
      sendByte(8'h02); sendByte(8'h05); sendByte(8'h11);
      idle(TIMEOUT);
      idle(2);
      checkOutput("t5_timeout_err", errCount - e0, 1);
      sendByte(8'h01); sendByte(8'h33);
      sendByte(8'h02); sendByte(8'h01); sendByte(8'hC3);
      idle(2);
      checkOutput("t5_ptr33", int'(mem[8'h33]), 8'hC3);
      checkOutput("t5_acks", ackCount - a0, 2);
      // Byte arriving on the exact expiry cycle is accepted.
      snap();
      sendByte(8'h02); sendByte(8'h05); sendByte(8'h11);
      idle(TIMEOUT - 1);
      sendByte(8'h22); sendByte(8'h33); sendByte(8'h44); sendByte(8'h55);
      idle(3);
      checkOutput("t5_expiry_no_err", errCount - e0, 0);
      checkOutput("t5_expiry_writes", writeCount - w0, 5);
      checkOutput("t5_expiry_acks", ackCount - a0, 1);

      // Bad opcode.
      snap();
      sendByte(8'h7F);
      idle(3);
      checkOutput("t6_bad_err", errCount - e0, 1);
      checkOutput("t6_bad_nowrite", writeCount - w0, 0);

      // Asynchronous reset in the middle of a fill.
      sendByte(8'h03); sendByte(8'h77);
      idle(50);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t7_rst_we", int'(ramWe), 0);
      checkOutput("t7_rst_busy", int'(busy), 0);
      checkOutput("t7_rst_addr", int'(ramAddr), 0);
      checkOutput("t7_rst_din", int'(ramDin), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      snap();
      sendByte(8'h01); sendByte(8'h44);
      sendByte(8'h02); sendByte(8'h01); sendByte(8'h99);
      idle(3);
      checkOutput("t7_after_rst_mem44", int'(mem[8'h44]), 8'h99);
      checkOutput("t7_after_rst_writes", writeCount - w0, 1);

      // Randomized command mix against the model.
      for (int n = 0; n < 80; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 2) begin
            sendByte(8'h01); idle($urandom_range(0, 2));
            sendByte(8'($urandom_range(0, 255)));
         end else if (r <= 6) begin
            int len;
            len = $urandom_range(1, 6);
            sendByte(8'h02); idle($urandom_range(0, 2));
            sendByte(8'(len));
            for (int k = 0; k < len; k++) begin
               idle($urandom_range(0, 2));
               sendByte(8'($urandom_range(0, 255)));
            end
         end else if (r == 7) begin
            sendByte(8'($urandom_range(4, 255)));
         end else if (r == 8) begin
            sendByte(8'h03); idle($urandom_range(0, 2));
            sendByte(8'($urandom_range(0, 255)));
            idle(RAMSIZE + 2);
         end else begin
            sendByte(8'h02); sendByte(8'h04);
            sendByte(8'($urandom_range(0, 255)));
            idle(TIMEOUT + 2);
         end
         idle($urandom_range(0, 3));
      end
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
